serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port start_i, input, 1 bit: request to start one subtraction.
REQ-005 The module SHALL have port a_i, input, WIDTH bits: minuend, unsigned.
REQ-006 The module SHALL have port b_i, input, WIDTH bits: subtrahend, unsigned.
REQ-007 The module SHALL have port busy_o, output, 1 bit: high while an operation is in progress (RUN or DONE).
REQ-008 The module SHALL have port valid_o, output, 1 bit: one-cycle pulse marking diff_o/borrow_o as a new result.
REQ-009 The module SHALL have port diff_o, output, WIDTH bits: (a - b) mod 2^WIDTH.
REQ-010 The module SHALL have port borrow_o, output, 1 bit: final borrow, high iff a < b.

Function
REQ-011 The module SHALL implement a bit-serial subtractor: one half-subtract/full-subtract bit slice, LSB first, one bit per clock, with a 1-bit borrow register.
REQ-012 The module SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE with start_i=1 at a rising edge, the module SHALL capture a_i and b_i into internal shift registers, clear the borrow register and bit counter, and go to RUN.
REQ-014 In IDLE with start_i=0, the module SHALL remain in IDLE with all registers unchanged.
REQ-015 In RUN, each edge SHALL compute d = a0 ^ b0 ^ br and br' = (~a0 & b0) | (~(a0 ^ b0) & br) on the current LSBs, shift d into the result register MSB-side, shift both operand registers right by one, and increment the counter.
REQ-016 After exactly WIDTH RUN cycles (counter reaching WIDTH-1 and being processed), the FSM SHALL go to DONE.
REQ-017 In DONE, valid_o SHALL be 1 for exactly that one cycle, and the FSM SHALL return to IDLE at the next edge.
REQ-018 Latency: if start_i is sampled at edge E0, valid_o SHALL be high in the cycle following edge E0+WIDTH+1.
REQ-019 diff_o and borrow_o SHALL be registered and SHALL hold the last result unchanged until the next DONE; they are undefined only before the first operation (reset value 0).
REQ-020 busy_o SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-021 start_i asserted in RUN or DONE SHALL be ignored (no restart, no queuing); a new operation can start only from IDLE, so minimum start-to-start spacing is WIDTH+2 cycles.
REQ-022 Changes on a_i/b_i after the capture edge SHALL have no effect on the running operation.
REQ-023 Wrap-around: the result SHALL be modulo 2^WIDTH, with borrow_o carrying the out-of-range indication; no saturation.
REQ-024 Equal operands SHALL yield diff_o=0 and borrow_o=0.

Reset
REQ-025 When rst_i=1 at a rising edge, the module SHALL go to IDLE and clear busy_o, valid_o, diff_o, borrow_o, the borrow register, the counter and the operand registers, regardless of state.
REQ-026 Reset SHALL take priority over start_i; an operation interrupted by reset SHALL produce no valid_o pulse.
REQ-027 Outputs SHALL not change asynchronously to clk_i.

Verification (WIDTH=8)
REQ-028 a=0x5A, b=0x3C, start for one cycle -> busy_o for 9 cycles, valid_o one cycle at E0+9, diff_o=0x1E, borrow_o=0.
REQ-029 a=0x00, b=0x01 -> diff_o=0xFF, borrow_o=1; a=0xFF, b=0x00 -> diff_o=0xFF, borrow_o=0.
REQ-030 a=0x80, b=0x80 -> diff_o=0x00, borrow_o=0; previous result holds on diff_o until this valid_o.
REQ-031 start_i held high continuously with operands changing every cycle -> results match the operands sampled at each IDLE start only, spacing 10 cycles, one valid_o each.
REQ-032 rst_i=1 for one cycle at the 4th RUN cycle of a=0x5A, b=0x3C -> next cycle IDLE, all outputs 0, no valid_o; a new start afterwards completes correctly.
REQ-033 Randomised loop of 1000 operand pairs checked against a reference (a-b) mod 256 and a<b.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtract slice, LSB first, one bit per clock.
// Result and final borrow are registered and held until the next completed operation.
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic a0_c;
    logic b0_c;
    logic d_c;
    logic br_nx_c;

    // Full-subtract slice on the current operand LSBs
    assign a0_c    = a_sr[0];
    assign b0_c    = b_sr[0];
    assign d_c     = a0_c ^ b0_c ^ br;
    assign br_nx_c = (~a0_c & b0_c) | (~(a0_c ^ b0_c) & br);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_sr   <= a_i;
                        b_sr   <= b_i;
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d_c, res_sr[WIDTH-1:1]};
                    br     <= br_nx_c;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Publish the result as the FSM drops back to IDLE
                    diff_o   <= res_sr;
                    borrow_o <= br;
                    valid_o  <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): directed vector table, multi-cycle
// corner sequences (continuous start, mid-run reset) and a random operand sweep.
module tb_serial_sub;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] prev_d;
    logic             prev_br;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a_in),
        .b_i     (b_in),
        .busy_o  (busy),
        .valid_o (valid),
        .diff_o  (diff),
        .borrow_o(borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_br;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] op_a(input int c);
        return 8'(c * 37 + 5);
    endfunction

    function automatic logic [7:0] op_b(input int c);
        return 8'(c * 11 + 90);
    endfunction

    // One operation from IDLE; watches busy/valid timing and the held result
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eb, input bit full);
        int busy_cnt;
        int v_cnt;
        int lat;
        logic [7:0] d_got;
        logic       b_got;
        busy_cnt = 0;
        v_cnt    = 0;
        lat      = -1;
        d_got    = '0;
        b_got    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (valid) begin
                v_cnt++;
                lat   = k;
                d_got = diff;
                b_got = borrow;
            end
            if (full && k == 8) begin
                check("hold_diff", 32'(diff), 32'(prev_d));
                check("hold_borrow", 32'(borrow), 32'(prev_br));
            end
            a_in = 8'($urandom);
            b_in = 8'($urandom);
        end
        if (full) begin
            check("busy_cycles", 32'(busy_cnt), 32'd9);
            check("latency", 32'(lat), 32'd9);
        end
        check("valid_count", 32'(v_cnt), 32'd1);
        check("diff", 32'(d_got), 32'(ed));
        check("borrow", 32'(b_got), 32'(eb));
        prev_d  = ed;
        prev_br = eb;
    endtask

    vec_t vecs[10];

    initial begin
        int nv;
        int vc;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b0};
        vecs[4] = '{8'h3C, 8'h5A, 8'hE2, 1'b1};
        vecs[5] = '{8'h01, 8'hFF, 8'h02, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[8] = '{8'h10, 8'h01, 8'h0F, 1'b0};
        vecs[9] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

        rst     = 1'b1;
        start   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        prev_d  = '0;
        prev_br = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_br, 1'b1);
        end

        // Reset during the 4th RUN cycle aborts the operation silently
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'h5A;
        b_in  = 8'h3C;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        vc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (valid || busy) vc++;
        end
        check("abort_no_activity", 32'(vc), 32'd0);
        prev_d  = '0;
        prev_br = 1'b0;
        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b1);

        // start held high with operands changing every cycle: captures at 0,10,20,30
        @(negedge clk);
        start = 1'b1;
        a_in  = op_a(0);
        b_in  = op_b(0);
        @(posedge clk);
        nv = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (valid) begin
                ra = op_a(10 * nv);
                rb = op_b(10 * nv);
                check("cont_spacing", 32'(k), 32'(9 + 10 * nv));
                check("cont_diff", 32'(diff), 32'(8'(ra - rb)));
                check("cont_borrow", 32'(borrow), 32'(ra < rb));
                nv++;
            end
            a_in = op_a(k + 1);
            b_in = op_b(k + 1);
        end
        start = 1'b0;
        check("cont_valid_count", 32'(nv), 32'd3);
        repeat (12) @(negedge clk);
        ra      = op_a(30);
        rb      = op_b(30);
        prev_d  = 8'(ra - rb);
        prev_br = ra < rb;
        check("cont_last_diff", 32'(diff), 32'(prev_d));

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 8'(ra - rb), ra < rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
